td4_exec_ctrl: RTL
==================

TD4_EXEC_CTRL -- requirements
Module: td4_exec_ctrl

Interface
REQ-001 Parameter PC_W, default 8: width of the CPU program counter and breakpoint address.
REQ-002 Parameter RST_CYCLES, default 4: number of cycles cpu_rst is held after any reset event.
REQ-003 Parameter DIV_W, default 16: width of the run-rate divisor.
REQ-004 CLOCK  in  1  sole clock; all state changes on its rising edge.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 run_req  in  1  single-cycle pulse; enter free-run.
REQ-007 step_req  in  1  single-cycle pulse; execute exactly one instruction.
REQ-008 halt_req  in  1  single-cycle pulse; stop execution.
REQ-009 soft_rst_req  in  1  single-cycle pulse; restart the CPU-reset hold sequence.
REQ-010 div  in  DIV_W  run-rate divisor; idle cycles inserted before each enable pulse.
REQ-011 bp_en  in  1  breakpoint enable.
REQ-012 bp_addr  in  PC_W  breakpoint address.
REQ-013 pc  in  PC_W  current CPU PC register value.
REQ-014 cpu_ce  out  1  single-cycle clock enable gating all CPU register updates.
REQ-015 cpu_rst  out  1  active-high synchronous reset to the CPU.
REQ-016 state  out  3  current controller state encoding.
REQ-017 halted_bp  out  1  sticky flag: last halt caused by a breakpoint.
REQ-018 halted_loop  out  1  sticky flag: last halt caused by a self-jump (PC unchanged after an enable).
REQ-019 step_count  out  16  number of cpu_ce pulses since the last reset hold; saturates at 0xFFFF.

Function
REQ-020 States SHALL be RSTHOLD, IDLE, RUN, STEP and CHECK.
REQ-021 RSTHOLD SHALL assert cpu_rst for exactly RST_CYCLES cycles, hold cpu_ce=0, clear step_count and both flags, then go to IDLE.
REQ-022 IDLE SHALL go to STEP on step_req, else to RUN on run_req; step_req wins when both are asserted.
REQ-023 IDLE SHALL go to RSTHOLD on soft_rst_req, which takes priority over step_req and run_req.
REQ-024 Leaving IDLE for RUN or STEP SHALL clear halted_bp and halted_loop.
REQ-025 RUN SHALL count prescaler cycles 0..div and assert cpu_ce for one cycle when the count equals div, then go to CHECK; div=0 gives cpu_ce on the first RUN cycle.
REQ-026 STEP SHALL assert cpu_ce for exactly one cycle, latch pc into pc_prev, then go to CHECK.
REQ-027 The RUN cpu_ce cycle SHALL also latch pc into pc_prev.
REQ-028 CHECK SHALL assert no cpu_ce and SHALL evaluate the post-update pc.
REQ-029 In CHECK, priority is halt_req, then breakpoint, then loop, then continue.
REQ-030 CHECK breakpoint: if bp_en and pc==bp_addr, set halted_bp and go to IDLE.
REQ-031 CHECK loop: if pc==pc_prev, set halted_loop and go to IDLE.
REQ-032 CHECK continue: after a step, go to IDLE; after a run, go to RUN with the prescaler cleared.
REQ-033 Minimum RUN cpu_ce period SHALL be div+2 cycles.
REQ-034 halt_req in RUN SHALL go to IDLE on the next edge with no further cpu_ce.
REQ-035 halt_req coinciding with a cpu_ce cycle SHALL NOT suppress that pulse, but CHECK SHALL then go to IDLE.
REQ-036 soft_rst_req in any state SHALL go to RSTHOLD on the next edge, dropping any pending cpu_ce.
REQ-037 run_req in RUN and step_req outside IDLE SHALL be ignored.
REQ-038 step_count SHALL increment on each cpu_ce, hold at 0xFFFF, and wrap never.
REQ-039 pc comparisons SHALL be full PC_W-bit equality; a wrap of pc from 0xFF to 0x00 is a normal change, not a loop.
REQ-040 A change to div during RUN SHALL take effect from the next prescaler compare.

Reset
REQ-041 With RESET_N low, the controller SHALL set state=RSTHOLD, cpu_rst=1, cpu_ce=0, step_count=0, halted_bp=0, halted_loop=0, prescaler=0 and pc_prev=0.
REQ-042 The RSTHOLD cycle count SHALL start on the first rising edge after RESET_N deasserts.
REQ-043 RESET_N asserted mid-operation SHALL force these values immediately, asynchronously.

Structure
REQ-044 Shared package td4_pkg SHALL hold the state enum (3-bit) and the TD4 opcode constants (ADD_A..JMP), for reuse by the CPU and assembler tests.
REQ-045 The prescaler SHALL be a sub-module td4_prescaler with inputs clear, enable and div, and output tick.

Verification
REQ-046 Reset scenario: RESET_N low 3 cycles then high, RST_CYCLES=4 -> cpu_rst high for exactly 4 post-release cycles, then state=IDLE and step_count=0.
REQ-047 Run-rate scenario: run_req with div=3 -> cpu_ce pulses every 5 cycles; after 10 pulses step_count=10.
REQ-048 Breakpoint scenario: bp_en=1, bp_addr=0x05, model PC incrementing -> halt with pc=0x05, halted_bp=1, no cpu_ce after the CHECK cycle.
REQ-049 Self-jump scenario: model a JMP 0x14 at PC 0x14 -> halted_loop=1 after the first enable at 0x14, state=IDLE.
REQ-050 Simultaneous-request scenario: step_req and run_req together in IDLE -> exactly one cpu_ce, return to IDLE; a further step_req gives one more pulse.
REQ-051 Halt/soft-reset scenario: halt_req on the cpu_ce cycle -> that pulse is kept, then IDLE; soft_rst_req in RUN -> cpu_rst for 4 cycles and step_count cleared.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared TD4 definitions: execution-controller state encoding and the CPU
// opcode map, reused by the CPU core and the assembler tests.
package td4_pkg;

  typedef enum logic [2:0] {
    ST_RSTHOLD = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RUN     = 3'd2,
    ST_STEP    = 3'd3,
    ST_CHECK   = 3'd4
  } ctrl_state_e;

  // Upper nibble of each TD4 instruction byte; the lower nibble is the immediate.
  localparam logic [3:0] OP_ADD_A   = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B = 4'b0001;
  localparam logic [3:0] OP_IN_A    = 4'b0010;
  localparam logic [3:0] OP_MOV_A   = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A = 4'b0100;
  localparam logic [3:0] OP_ADD_B   = 4'b0101;
  localparam logic [3:0] OP_IN_B    = 4'b0110;
  localparam logic [3:0] OP_MOV_B   = 4'b0111;
  localparam logic [3:0] OP_OUT_B   = 4'b1001;
  localparam logic [3:0] OP_OUT_IM  = 4'b1011;
  localparam logic [3:0] OP_JNC     = 4'b1110;
  localparam logic [3:0] OP_JMP     = 4'b1111;

  function automatic logic is_jump(input logic [3:0] op);
    return (op == OP_JNC) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/td4_prescaler.sv
// Run-rate prescaler: counts 0..div while enabled and ticks on the last count.
module td4_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // >= so that lowering div below the running count still ticks at the next compare.
  assign tick = enable && (cnt >= div);

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/td4_exec_ctrl.sv
// TD4 execution controller: CPU reset sequencing, free-run / single-step
// clock-enable generation, and breakpoint / self-jump halt detection.
module td4_exec_ctrl
  import td4_pkg::*;
#(
  parameter int PC_W       = 8,
  parameter int RST_CYCLES = 4,
  parameter int DIV_W      = 16
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             soft_rst_req,
  input  logic [DIV_W-1:0] div,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_ce,
  output logic             cpu_rst,
  output logic [2:0]       state,
  output logic             halted_bp,
  output logic             halted_loop,
  output logic [15:0]      step_count
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  ctrl_state_e      state_q, state_d;
  logic [RC_W-1:0]  rst_cnt;
  logic             rst_done;
  logic             halt_pend;
  logic             from_step;
  logic [PC_W-1:0]  pc_prev;
  logic             tick;
  logic             bp_hit, loop_hit, halt_now;
  logic             set_bp, set_loop;

  td4_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .clear   (state_q != ST_RUN),
    .enable  (state_q == ST_RUN),
    .div     (div),
    .tick    (tick)
  );

  assign rst_done = (rst_cnt == RC_W'(RST_CYCLES - 1));
  assign bp_hit   = bp_en && (pc == bp_addr);
  assign loop_hit = (pc == pc_prev);
  // A halt that arrived with the enable pulse is remembered into CHECK.
  assign halt_now = halt_req || halt_pend;
  assign state    = state_q;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_RSTHOLD;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (soft_rst_req) begin
      state_d = ST_RSTHOLD;
    end else begin
      case (state_q)
        ST_RSTHOLD: if (rst_done) state_d = ST_IDLE;
        ST_IDLE: begin
          if (step_req)     state_d = ST_STEP;
          else if (run_req) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (tick)          state_d = ST_CHECK;
          else if (halt_req) state_d = ST_IDLE;
        end
        ST_STEP:  state_d = ST_CHECK;
        ST_CHECK: begin
          if (halt_now || bp_hit || loop_hit || from_step) state_d = ST_IDLE;
          else                                             state_d = ST_RUN;
        end
        default:  state_d = ST_RSTHOLD;
      endcase
    end
  end

  always_comb begin
    cpu_ce   = 1'b0;
    cpu_rst  = 1'b0;
    set_bp   = 1'b0;
    set_loop = 1'b0;
    case (state_q)
      ST_RSTHOLD: cpu_rst = 1'b1;
      ST_RUN:     cpu_ce  = tick && !soft_rst_req;
      ST_STEP:    cpu_ce  = !soft_rst_req;
      ST_CHECK: begin
        if (!soft_rst_req && !halt_now) begin
          set_bp   = bp_hit;
          set_loop = !bp_hit && loop_hit;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rst_cnt     <= '0;
      halt_pend   <= 1'b0;
      from_step   <= 1'b0;
      pc_prev     <= '0;
      step_count  <= '0;
      halted_bp   <= 1'b0;
      halted_loop <= 1'b0;
    end else begin
      // Hold counter runs only while staying in RSTHOLD; a soft reset restarts it.
      if (state_q == ST_RSTHOLD && state_d == ST_RSTHOLD && !soft_rst_req)
        rst_cnt <= rst_cnt + 1'b1;
      else
        rst_cnt <= '0;

      halt_pend <= cpu_ce && halt_req;
      if (state_q == ST_IDLE) from_step <= (state_d == ST_STEP);
      if (cpu_ce) pc_prev <= pc;

      if (state_d == ST_RSTHOLD) begin
        step_count  <= '0;
        halted_bp   <= 1'b0;
        halted_loop <= 1'b0;
      end else begin
        if (cpu_ce && step_count != 16'hFFFF) step_count <= step_count + 16'd1;
        if (state_q == ST_IDLE && state_d != ST_IDLE) begin
          halted_bp   <= 1'b0;
          halted_loop <= 1'b0;
        end else begin
          if (set_bp)   halted_bp   <= 1'b1;
          if (set_loop) halted_loop <= 1'b1;
        end
      end
    end
  end

endmodule
